regbank_port_ctrl: RTL and testbench

//  Requester side of the DiBU register bank. It owns the bank's single rw/index port.
//  It accepts operand-read requests from decode and write-back requests from the ALU.

---
 rtl/dibu_pkg.sv | 17 +
 rtl/regbank_wr_fifo.sv | 97 +++++++++
 rtl/regbank_port_ctrl.sv | 129 ++++++++++++
 tb/tb_regbank_port_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dibu_pkg.sv
// Shared definitions for the DiBU register-bank requester: widths, FSM states
// and bank operation codes.
package dibu_pkg;

  localparam int unsigned DATA_W   = 8;
  localparam int unsigned IDX_W    = 3;
  localparam int unsigned WQ_DEPTH = 4;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_RD_WAIT = 1'b1
  } state_e;

  localparam logic RB_READ  = 1'b0;
  localparam logic RB_WRITE = 1'b1;

endpackage

// File: rtl/regbank_wr_fifo.sv
// In-order write-back queue for the register bank, with per-entry valid bits so
// two read indices can be checked against every pending write in one cycle.
module regbank_wr_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned IDX_W  = 3,
  parameter int unsigned DEPTH  = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [IDX_W-1:0]  push_idx,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [IDX_W-1:0]  head_idx,
  output logic [DATA_W-1:0] head_data,
  output logic              full,
  output logic              empty,
  input  logic [IDX_W-1:0]  q_idx_a,
  input  logic [IDX_W-1:0]  q_idx_b,
  output logic              match_a,
  output logic              match_b
);

  logic [IDX_W-1:0]  idx_q  [DEPTH];
  logic [IDX_W-1:0]  idx_d  [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [DEPTH-1:0]  vld_q, vld_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    cnt_q, cnt_d;
  logic              push_en, pop_en;

  assign full      = (cnt_q == (PTR_W+1)'(DEPTH));
  assign empty     = (cnt_q == '0);
  assign push_en   = push && !full;
  assign pop_en    = pop && !empty;
  assign head_idx  = idx_q[rd_ptr_q];
  assign head_data = data_q[rd_ptr_q];

  always_comb begin
    idx_d    = idx_q;
    data_d   = data_q;
    vld_d    = vld_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    // Push and pop never address the same slot: that needs full or empty,
    // which disables the respective side.
    if (push_en) begin
      idx_d[wr_ptr_q]  = push_idx;
      data_d[wr_ptr_q] = push_data;
      vld_d[wr_ptr_q]  = 1'b1;
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
    end
    if (pop_en) begin
      vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d        = rd_ptr_q + PTR_W'(1);
    end
    case ({push_en, pop_en})
      2'b10:   cnt_d = cnt_q + (PTR_W+1)'(1);
      2'b01:   cnt_d = cnt_q - (PTR_W+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    match_a = 1'b0;
    match_b = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && (idx_q[i] == q_idx_a)) match_a = 1'b1;
      if (vld_q[i] && (idx_q[i] == q_idx_b)) match_b = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        idx_q[i]  <= '0;
        data_q[i] <= '0;
      end
      vld_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      idx_q    <= idx_d;
      data_q   <= data_d;
      vld_q    <= vld_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/regbank_port_ctrl.sv
// Owner of the register bank's single rw/index port: multiplexes operand reads
// and queued write-backs, stalling reads that would observe a pending write.
module regbank_port_ctrl #(
  parameter int unsigned DATA_W   = dibu_pkg::DATA_W,
  parameter int unsigned IDX_W    = dibu_pkg::IDX_W,
  parameter int unsigned WQ_DEPTH = dibu_pkg::WQ_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_req,
  input  logic [IDX_W-1:0]  rd_ri_a,
  input  logic [IDX_W-1:0]  rd_ri_b,
  output logic              rd_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_a,
  output logic [DATA_W-1:0] rd_b,
  input  logic              wr_req,
  input  logic [IDX_W-1:0]  wr_ri,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic [IDX_W-1:0]  rb_ri_a,
  output logic [IDX_W-1:0]  rb_ri_b,
  output logic [IDX_W-1:0]  rb_ri_d,
  output logic              rb_rw,
  output logic [DATA_W-1:0] rb_d,
  input  logic [DATA_W-1:0] rb_a,
  input  logic [DATA_W-1:0] rb_b
);

  import dibu_pkg::*;

  state_e            state_q, state_d;
  logic              rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0] rd_a_q, rd_a_d;
  logic [DATA_W-1:0] rd_b_q, rd_b_d;

  logic              q_full, q_empty, q_push, q_pop;
  logic              match_a, match_b, hazard;
  logic [IDX_W-1:0]  head_idx;
  logic [DATA_W-1:0] head_data;

  // Hazard looks only at already-queued entries, so a write accepted alongside
  // a read lands after it and the read returns the old value.
  assign hazard   = match_a | match_b;
  assign wr_ready = !q_full;
  assign q_push   = wr_req && !q_full && !rst;

  regbank_wr_fifo #(
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W),
    .DEPTH  (WQ_DEPTH)
  ) u_wr_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (q_push),
    .push_idx  (wr_ri),
    .push_data (wr_data),
    .pop       (q_pop),
    .head_idx  (head_idx),
    .head_data (head_data),
    .full      (q_full),
    .empty     (q_empty),
    .q_idx_a   (rd_ri_a),
    .q_idx_b   (rd_ri_b),
    .match_a   (match_a),
    .match_b   (match_b)
  );

  always_comb begin
    state_d    = state_q;
    rd_valid_d = 1'b0;
    rd_a_d     = rd_a_q;
    rd_b_d     = rd_b_q;
    rd_ready   = 1'b0;
    q_pop      = 1'b0;
    rb_rw      = RB_READ;
    rb_ri_a    = '0;
    rb_ri_b    = '0;
    rb_ri_d    = '0;
    rb_d       = '0;

    case (state_q)
      ST_IDLE: begin
        rd_ready = !hazard;
        if (rd_req && !hazard) begin
          rb_ri_a = rd_ri_a;
          rb_ri_b = rd_ri_b;
          state_d = ST_RD_WAIT;
        end else begin
          q_pop = !q_empty;
        end
      end
      ST_RD_WAIT: begin
        rd_valid_d = 1'b1;
        rd_a_d     = rb_a;
        rd_b_d     = rb_b;
        q_pop      = !q_empty;
        state_d    = ST_IDLE;
      end
    endcase

    if (rst) q_pop = 1'b0;

    if (q_pop) begin
      rb_rw   = RB_WRITE;
      rb_ri_d = head_idx;
      rb_d    = head_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rd_valid_q <= 1'b0;
      rd_a_q     <= '0;
      rd_b_q     <= '0;
    end else begin
      state_q    <= state_d;
      rd_valid_q <= rd_valid_d;
      rd_a_q     <= rd_a_d;
      rd_b_q     <= rd_b_d;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_a     = rd_a_q;
  assign rd_b     = rd_b_q;

endmodule

// File: tb/tb_regbank_port_ctrl.sv
// Scoreboard bench for regbank_port_ctrl with a behavioural register bank.
module tb_regbank_port_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       rd_req;
  logic [2:0] rd_ri_a, rd_ri_b;
  logic       rd_ready, rd_valid;
  logic [7:0] rd_a, rd_b;
  logic       wr_req;
  logic [2:0] wr_ri;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic [2:0] rb_ri_a, rb_ri_b, rb_ri_d;
  logic       rb_rw;
  logic [7:0] rb_d;
  logic [7:0] rb_a = 8'h00;
  logic [7:0] rb_b = 8'h00;

  regbank_port_ctrl #(
    .DATA_W   (8),
    .IDX_W    (3),
    .WQ_DEPTH (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rd_req   (rd_req),
    .rd_ri_a  (rd_ri_a),
    .rd_ri_b  (rd_ri_b),
    .rd_ready (rd_ready),
    .rd_valid (rd_valid),
    .rd_a     (rd_a),
    .rd_b     (rd_b),
    .wr_req   (wr_req),
    .wr_ri    (wr_ri),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .rb_ri_a  (rb_ri_a),
    .rb_ri_b  (rb_ri_b),
    .rb_ri_d  (rb_ri_d),
    .rb_rw    (rb_rw),
    .rb_d     (rb_d),
    .rb_a     (rb_a),
    .rb_b     (rb_b)
  );

  always #5 clk = ~clk;

  // Register bank: outputs change only on read edges.
  logic [7:0] bank_mem [8];
  initial for (int i = 0; i < 8; i++) bank_mem[i] = 8'h00;
  always @(posedge clk) begin
    if (rb_rw) bank_mem[rb_ri_d] <= rb_d;
    else begin
      rb_a <= bank_mem[rb_ri_a];
      rb_b <= bank_mem[rb_ri_b];
    end
  end

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    int unsigned cyc;
  } rd_exp_t;
  typedef struct {
    logic [2:0] idx;
    logic [7:0] data;
  } wr_exp_t;

  rd_exp_t     rd_exp_q[$];
  wr_exp_t     wr_exp_q[$];
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          rd_seen = 0;
  int          wr_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor: compare every read result and every bank write against the queues.
  always @(negedge clk) begin
    if (!rst) begin
      if (rd_valid) begin
        rd_seen++;
        if (rd_exp_q.size() == 0) chk("rd_unexpected", 1, 0);
        else begin
          rd_exp_t e;
          e = rd_exp_q.pop_front();
          chk("rd_a", rd_a, e.a);
          chk("rd_b", rd_b, e.b);
          chk("rd_latency_cycle", cyc, e.cyc);
        end
      end
      if (rb_rw) begin
        wr_seen++;
        if (wr_exp_q.size() == 0) chk("bank_wr_unexpected", 1, 0);
        else begin
          wr_exp_t w;
          w = wr_exp_q.pop_front();
          chk("bank_wr_idx", rb_ri_d, w.idx);
          chk("bank_wr_data", rb_d, w.data);
        end
      end
    end
  end

  // One cycle of stimulus; expectations are queued on handshake acceptance.
  task automatic try_cycle(input bit rd, input logic [2:0] a, input logic [2:0] b,
                           input logic [7:0] ea, input logic [7:0] eb,
                           input bit wr, input logic [2:0] wi, input logic [7:0] wd,
                           output bit rd_ok, output bit wr_ok);
    @(posedge clk); #1;
    rd_req = rd; rd_ri_a = a; rd_ri_b = b;
    wr_req = wr; wr_ri = wi; wr_data = wd;
    @(negedge clk);
    rd_ok = rd && rd_ready;
    wr_ok = wr && wr_ready;
    if (rd_ok) rd_exp_q.push_back('{a: ea, b: eb, cyc: cyc + 2});
    if (wr_ok) wr_exp_q.push_back('{idx: wi, data: wd});
  endtask

  task automatic idle(input int n);
    bit r, w;
    for (int i = 0; i < n; i++) try_cycle(1'b0, '0, '0, '0, '0, 1'b0, '0, '0, r, w);
  endtask

  task automatic do_read(input logic [2:0] a, input logic [2:0] b,
                         input logic [7:0] ea, input logic [7:0] eb, output int stalls);
    bit r, w;
    r = 1'b0;
    stalls = 0;
    for (int t = 0; t < 20; t++) begin
      try_cycle(1'b1, a, b, ea, eb, 1'b0, '0, '0, r, w);
      if (r) break;
      stalls++;
    end
    if (!r) chk("rd_accept_timeout", 0, 1);
    idle(1);
  endtask

  task automatic do_write(input logic [2:0] wi, input logic [7:0] wd);
    bit r, w;
    w = 1'b0;
    for (int t = 0; t < 20; t++) begin
      try_cycle(1'b0, '0, '0, '0, '0, 1'b1, wi, wd, r, w);
      if (w) break;
    end
    if (!w) chk("wr_accept_timeout", 0, 1);
    idle(1);
  endtask

  task automatic wait_drain(input string name);
    for (int t = 0; t < 40; t++) begin
      if (rd_exp_q.size() == 0 && wr_exp_q.size() == 0) break;
      idle(1);
    end
    chk(name, rd_exp_q.size() + wr_exp_q.size(), 0);
  endtask

  initial begin
    int         st;
    bit         rok, wok;
    int         wi, wstall, rd_snap, wr_snap;
    logic [2:0] widx [8];
    logic [7:0] wdat [8];

    rst = 1'b1; rd_req = 1'b0; rd_ri_a = '0; rd_ri_b = '0;
    wr_req = 1'b0; wr_ri = '0; wr_data = '0;

    // 1: reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_ready", rd_ready, 1);
    chk("rst_wr_ready", wr_ready, 1);
    chk("rst_rb_rw", rb_rw, 0);
    chk("rst_rd_a", rd_a, 0);
    chk("rst_rd_b", rd_b, 0);
    @(posedge clk); #1 rst = 1'b0;

    // 2: idle write drains next cycle, then read it back
    do_write(3'd3, 8'h5A);
    chk("t2_drain_rw", rb_rw, 1);
    chk("t2_drain_idx", rb_ri_d, 3);
    chk("t2_drain_data", rb_d, 8'h5A);
    do_write(3'd7, 8'h77);
    wait_drain("t2_writes_drained");
    do_read(3'd3, 3'd0, 8'h5A, 8'h00, st);
    chk("t2_read_stalls", st, 0);
    wait_drain("t2_read_done");

    // 3: read right behind a write to the same register stalls one cycle
    try_cycle(1'b0, '0, '0, '0, '0, 1'b1, 3'd2, 8'h11, rok, wok);
    chk("t3_wr_accept", wok, 1);
    do_read(3'd2, 3'd5, 8'h11, 8'h00, st);
    chk("t3_read_stalls", st, 1);
    wait_drain("t3_done");

    // 4: writes every cycle while reads run; queue fills once
    widx = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0, 3'd1};
    wdat = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h20, 8'h21};
    wi = 0; wstall = 0;
    for (int c = 0; c < 40 && wi < 8; c++) begin
      try_cycle(1'b1, 3'd7, 3'd7, 8'h77, 8'h77, 1'b1, widx[wi], wdat[wi], rok, wok);
      if (wok) wi++;
      else wstall++;
    end
    idle(1);
    chk("t4_writes_accepted", wi, 8);
    chk("t4_full_stalls", wstall, 1);
    wait_drain("t4_done");

    // 5: read and write of the same register in one cycle returns the old value
    do_write(3'd6, 8'h33);
    wait_drain("t5_seed");
    try_cycle(1'b1, 3'd6, 3'd6, 8'h33, 8'h33, 1'b1, 3'd6, 8'hAA, rok, wok);
    chk("t5_both_accepted", {30'd0, rok, wok}, 3);
    idle(1);
    wait_drain("t5_old_value");
    do_read(3'd6, 3'd6, 8'hAA, 8'hAA, st);
    wait_drain("t5_new_value");

    // 6: reset while a read is in flight and two writes are queued
    try_cycle(1'b0, '0, '0, '0, '0, 1'b1, 3'd1, 8'h55, rok, wok);
    try_cycle(1'b1, 3'd7, 3'd7, 8'h77, 8'h77, 1'b1, 3'd2, 8'h66, rok, wok);
    chk("t6_setup_accepted", {30'd0, rok, wok}, 3);
    @(posedge clk); #1;
    rst = 1'b1; rd_req = 1'b0; wr_req = 1'b0;
    @(negedge clk);
    chk("t6_rb_rw_in_rst", rb_rw, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    rd_exp_q.delete();
    wr_exp_q.delete();
    rd_snap = rd_seen; wr_snap = wr_seen;
    idle(8);
    chk("t6_no_rd_valid", rd_seen - rd_snap, 0);
    chk("t6_no_bank_write", wr_seen - wr_snap, 0);
    chk("t6_wr_ready", wr_ready, 1);
    chk("t6_rd_ready", rd_ready, 1);
    do_read(3'd1, 3'd2, 8'h21, 8'h12, st);
    wait_drain("t6_discarded_writes");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
